riscv_if_fetchq: RTL and testbench

Parametrised instruction-fetch stage with a halfword prefetch queue. It replaces the single-word fetch and realign path between the ICACHE and the ID stage. The cache is read one word at a time with at most one request outstanding, and the returned word is split into 16-bit parcels in a circular queue. Each cycle one aligned 32-bit or compressed (RVC) instruction is drained into the IF/ID pipeline registers, with support for stall, flush and PC correction from EX.

---
 rtl/riscv_if_fetchq.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_if_fetchq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_if_fetchq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : riscv_if_fetchq                                               |
// | Desc     : Instruction fetch stage with a halfword prefetch queue that    |
// |            feeds aligned 32-bit / RVC instructions into the IF/ID regs.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module riscv_if_fetchq #(
  parameter int unsigned QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          RVC_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        make_correction,
  input  logic [31:0] pc_correction,
  input  logic        ICACHE_stall,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  output logic [31:0] ICACHE_wdata,
  output logic [31:0] inst_ppl,
  output logic [31:0] pc_ppl,
  output logic        compressed_ppl,
  output logic [31:0] PC
);

  localparam int                   c_ptr_w     = $clog2(QDEPTH);
  localparam int                   c_cnt_w     = c_ptr_w + 1;
  localparam logic [1:0]           c_st_idle   = 2'd0;
  localparam logic [1:0]           c_st_req    = 2'd1;
  localparam logic [1:0]           c_st_drop   = 2'd2;
  localparam logic [31:0]          c_nop       = 32'h0000_0013;
  localparam logic [c_ptr_w-1:0]   c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]   c_cnt_two   = c_cnt_w'(2);
  localparam logic [c_cnt_w-1:0]   c_cnt_depth = c_cnt_w'(QDEPTH);

  logic [15:0]         r_ram [QDEPTH];
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [31:0]         r_pc;
  logic [31:0]         r_fetch_pc;
  logic [29:0]         r_drop_addr;
  logic [1:0]          r_state;
  logic [31:0]         r_inst;
  logic [31:0]         r_pc_ppl;
  logic                r_comp;

  logic [1:0]          w_state_nxt;
  logic                w_ren;
  logic [29:0]         w_addr;
  logic                w_resp;
  logic                w_wr;
  logic                w_is_c;
  logic                w_ready;
  logic                w_consume;
  logic [15:0]         w_head;
  logic [15:0]         w_head_nxt;
  logic [c_cnt_w-1:0]  w_len;
  logic [c_cnt_w-1:0]  w_free;
  logic [c_cnt_w-1:0]  w_wr_n;
  logic [c_cnt_w-1:0]  w_cons_n;
  logic [31:0]         w_target;
  logic                w_unused;

  // Halfword alignment is only meaningful when compressed code is enabled.
  assign w_target   = {pc_correction[31:2], pc_correction[1] & RVC_EN, 1'b0};
  assign w_unused   = pc_correction[0];

  assign w_head     = r_ram[r_rd_ptr];
  assign w_head_nxt = r_ram[r_rd_ptr + c_ptr_one];
  assign w_is_c     = RVC_EN && (w_head[1:0] != 2'b11);
  assign w_len      = w_is_c ? c_cnt_one : c_cnt_two;
  assign w_ready    = (r_count >= w_len);
  assign w_free     = c_cnt_depth - r_count;
  assign w_consume  = !stall && !flush && w_ready && !make_correction;
  assign w_resp     = w_ren && !ICACHE_stall;
  assign w_wr       = w_resp && (r_state != c_st_drop) && !make_correction;
  assign w_wr_n     = !w_wr ? '0 : (r_fetch_pc[1] ? c_cnt_one : c_cnt_two);
  assign w_cons_n   = w_consume ? w_len : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_req: begin
        if (w_ren) begin
          if (!ICACHE_stall) begin
            w_state_nxt = c_st_idle;
          end else if (make_correction) begin
            w_state_nxt = c_st_drop;
          end else begin
            w_state_nxt = c_st_req;
          end
        end
      end
      c_st_drop: begin
        if (!ICACHE_stall) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // A dropped request keeps presenting the address the cache already accepted.
  always_comb begin
    w_ren  = 1'b0;
    w_addr = r_fetch_pc[31:2];
    case (r_state)
      c_st_idle: w_ren = (w_free >= c_cnt_two);
      c_st_req:  w_ren = 1'b1;
      c_st_drop: begin
        w_ren  = 1'b1;
        w_addr = r_drop_addr;
      end
      default:   w_ren = 1'b0;
    endcase
    if (rst) begin
      w_ren = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state != c_st_drop) begin
      r_drop_addr <= r_fetch_pc[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (r_fetch_pc[1]) begin
        r_ram[r_wr_ptr] <= ICACHE_rdata[31:16];
      end else begin
        r_ram[r_wr_ptr]             <= ICACHE_rdata[15:0];
        r_ram[r_wr_ptr + c_ptr_one] <= ICACHE_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else if (make_correction) begin
      r_rd_ptr   <= r_wr_ptr;
      r_count    <= '0;
      r_pc       <= w_target;
      r_fetch_pc <= w_target;
    end else begin
      if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + w_wr_n[c_ptr_w-1:0];
        r_fetch_pc <= {r_fetch_pc[31:2] + 30'd1, 2'b00};
      end
      if (w_consume) begin
        r_rd_ptr <= r_rd_ptr + w_len[c_ptr_w-1:0];
        r_pc     <= r_pc + (w_is_c ? 32'd2 : 32'd4);
      end
      r_count <= r_count + w_wr_n - w_cons_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst   <= '0;
      r_pc_ppl <= '0;
      r_comp   <= 1'b0;
    end else if (!stall) begin
      r_pc_ppl <= r_pc;
      if (flush || !w_ready) begin
        r_inst <= c_nop;
        r_comp <= 1'b0;
      end else begin
        r_inst <= w_is_c ? {16'h0000, w_head} : {w_head_nxt, w_head};
        r_comp <= w_is_c;
      end
    end
  end

  assign ICACHE_ren     = w_ren;
  assign ICACHE_wen     = 1'b0;
  assign ICACHE_addr    = w_addr;
  assign ICACHE_wdata   = 32'h0;
  assign inst_ppl       = r_inst;
  assign pc_ppl         = r_pc_ppl;
  assign compressed_ppl = r_comp;
  assign PC             = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_riscv_if_fetchq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_riscv_if_fetchq                                            |
// | Desc     : Scoreboard bench for riscv_if_fetchq with a word-array cache.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_riscv_if_fetchq;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        make_correction;
  logic [31:0] pc_correction;
  logic        ICACHE_stall;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic [31:0] ICACHE_wdata;
  logic [31:0] inst_ppl;
  logic [31:0] pc_ppl;
  logic        compressed_ppl;
  logic [31:0] PC;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  logic [31:0] mem [1024];
  exp_t        sb[$];
  exp_t        m_exp;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        last_load = 1'b0;

  always #5 clk = ~clk;

  riscv_if_fetchq #(
    .QDEPTH   (4),
    .RESET_PC (32'h100),
    .RVC_EN   (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .make_correction (make_correction),
    .pc_correction   (pc_correction),
    .ICACHE_stall    (ICACHE_stall),
    .ICACHE_ren      (ICACHE_ren),
    .ICACHE_wen      (ICACHE_wen),
    .ICACHE_addr     (ICACHE_addr),
    .ICACHE_rdata    (ICACHE_rdata),
    .ICACHE_wdata    (ICACHE_wdata),
    .inst_ppl        (inst_ppl),
    .pc_ppl          (pc_ppl),
    .compressed_ppl  (compressed_ppl),
    .PC              (PC)
  );

  always_comb ICACHE_rdata = mem[ICACHE_addr[9:0]];

  // A non-NOP value in the pipeline register after an unstalled edge is a new output.
  always @(posedge clk) last_load <= !stall && !rst;

  always @(negedge clk) begin
    if (last_load && inst_ppl != 32'h0000_0013) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: actual inst=%h pc=%h c=%0d required no output",
                 inst_ppl, pc_ppl, compressed_ppl);
      end else begin
        m_exp = sb.pop_front();
        if (inst_ppl !== m_exp.inst || pc_ppl !== m_exp.pc || compressed_ppl !== m_exp.c) begin
          n_fail++;
          $display("FAIL sb_out: actual inst=%h pc=%h c=%0d required inst=%h pc=%h c=%0d",
                   inst_ppl, pc_ppl, compressed_ppl, m_exp.inst, m_exp.pc, m_exp.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [31:0] inst, input logic [31:0] pc, input logic c);
    sb.push_back({inst, pc, c});
  endtask

  task automatic redirect(input logic [31:0] target);
    make_correction = 1'b1;
    pc_correction   = target;
    @(negedge clk);
    make_correction = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    mem[10'h040] = 32'h00A0_0093;
    mem[10'h060] = 32'h0001_4501;
    mem[10'h061] = 32'h0000_0513;
    mem[10'h080] = 32'h0010_0113;
    mem[10'h081] = 32'h0020_0193;
    mem[10'h100] = 32'h4581_4501;
    mem[10'h101] = 32'h4681_4601;
    mem[10'h140] = 32'hDEAD_BEE3;
    mem[10'h180] = 32'h0030_0213;
    mem[10'h181] = 32'h0040_0293;

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    make_correction = 1'b0; pc_correction = 32'h0; ICACHE_stall = 1'b0;

    // Reset and cold start
    repeat (2) @(negedge clk);
    #1;
    check("ren_in_reset", ICACHE_ren, 32'd0);
    check("pc_reset", PC, 32'h100);
    check("wen_const", ICACHE_wen, 32'd0);
    check("wdata_const", ICACHE_wdata, 32'h0);
    expect_out(32'h00A0_0093, 32'h100, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("c0_ren", ICACHE_ren, 32'd1);
    check("c0_addr", ICACHE_addr, 32'h40);
    check("c0_inst_rst", inst_ppl, 32'h0);
    check("c0_pcppl_rst", pc_ppl, 32'h0);
    check("c0_comp_rst", compressed_ppl, 32'd0);
    @(negedge clk); #1;
    check("c1_addr_b2b", ICACHE_addr, 32'h41);
    @(negedge clk); #1;
    check("c2_inst", inst_ppl, 32'h00A0_0093);
    check("c2_pcppl", pc_ppl, 32'h100);
    repeat (4) @(negedge clk);

    // Mixed RVC stream
    expect_out(32'h0000_4501, 32'h180, 1'b1);
    expect_out(32'h0000_0001, 32'h182, 1'b1);
    expect_out(32'h0000_0513, 32'h184, 1'b0);
    redirect(32'h180);
    #1;
    check("mix_pc", PC, 32'h180);
    check("mix_addr", ICACHE_addr, 32'h60);
    repeat (8) @(negedge clk);
    check("mix_drained", 32'(sb.size()), 32'd0);

    // Straddling 32-bit instruction after an odd-halfword redirect
    mem[10'h040] = 32'h0093_1234;
    mem[10'h041] = 32'h4501_00A0;
    expect_out(32'h00A0_0093, 32'h102, 1'b0);
    expect_out(32'h0000_4501, 32'h106, 1'b1);
    redirect(32'h103);
    #1;
    check("str_pc", PC, 32'h102);
    check("str_addr", ICACHE_addr, 32'h40);
    repeat (8) @(negedge clk);
    check("str_drained", 32'(sb.size()), 32'd0);

    // Backpressure: stall held for 10 cycles fills the 4-parcel queue
    expect_out(32'h0000_4501, 32'h400, 1'b1);
    expect_out(32'h0000_4581, 32'h402, 1'b1);
    expect_out(32'h0000_4601, 32'h404, 1'b1);
    expect_out(32'h0000_4681, 32'h406, 1'b1);
    stall = 1'b1;
    redirect(32'h400);
    #1;
    check("bp_pc", PC, 32'h400);
    repeat (2) @(negedge clk);
    #1;
    check("bp_ren_full", ICACHE_ren, 32'd0);
    @(negedge clk); #1;
    check("bp_ren_full2", ICACHE_ren, 32'd0);
    check("bp_inst_hold", inst_ppl, 32'h0000_0013);
    check("bp_pc_hold", PC, 32'h400);
    repeat (6) @(negedge clk);
    #1;
    check("bp_inst_hold2", inst_ppl, 32'h0000_0013);
    stall = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Correction while a miss is pending
    expect_out(32'h0010_0113, 32'h200, 1'b0);
    expect_out(32'h0020_0193, 32'h204, 1'b0);
    redirect(32'h500);
    ICACHE_stall = 1'b1;
    #1;
    check("miss_ren", ICACHE_ren, 32'd1);
    check("miss_addr", ICACHE_addr, 32'h140);
    @(negedge clk); #1;
    check("miss_addr_c1", ICACHE_addr, 32'h140);
    @(negedge clk);
    make_correction = 1'b1;
    pc_correction   = 32'h200;
    @(negedge clk);
    make_correction = 1'b0;
    #1;
    check("drop_pc", PC, 32'h200);
    check("drop_ren", ICACHE_ren, 32'd1);
    check("drop_addr", ICACHE_addr, 32'h140);
    @(negedge clk); #1;
    check("drop_addr_c4", ICACHE_addr, 32'h140);
    @(negedge clk);
    ICACHE_stall = 1'b0;
    #1;
    check("drop_addr_c5", ICACHE_addr, 32'h140);
    @(negedge clk); #1;
    check("post_drop_ren", ICACHE_ren, 32'd1);
    check("post_drop_addr", ICACHE_addr, 32'h80);
    repeat (8) @(negedge clk);
    check("drop_drained", 32'(sb.size()), 32'd0);

    // Flush with stall holds; flush alone inserts a NOP
    expect_out(32'h0030_0213, 32'h600, 1'b0);
    expect_out(32'h0040_0293, 32'h604, 1'b0);
    redirect(32'h600);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk); #1;
    check("fs_inst_hold", inst_ppl, 32'h0030_0213);
    check("fs_pcppl_hold", pc_ppl, 32'h600);
    check("fs_pc", PC, 32'h604);
    stall = 1'b0;
    @(negedge clk); #1;
    check("fl_inst_nop", inst_ppl, 32'h0000_0013);
    check("fl_pcppl", pc_ppl, 32'h604);
    check("fl_comp", compressed_ppl, 32'd0);
    check("fl_pc_same", PC, 32'h604);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
